// File: rtl/lsu_ctrl.sv
// Load/store unit controller: decodes width/sign, aligns store data and lanes, runs one bus access and extends load data.
// Optional feature: define LSU_TIMEOUT_EN to abort an access after 255 REQ cycles without bus_ack.
module lsu_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        is_store,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        stall,
   output logic        done,
   output logic        err,
   output logic [31:0] rdata,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata
);

   typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

   state_t      state_q;
   logic        done_q, err_q, req_q, we_q;
   logic [31:0] addr_q, wdata_q, rdata_q;
   logic [3:0]  be_q;
   logic [2:0]  f3_q;
   logic [1:0]  off_q;
`ifdef LSU_TIMEOUT_EN
   logic [7:0]  tmo_q;
`endif

   logic        illegal;
   logic [3:0]  be_d;
   logic [31:0] wdata_d;
   logic [31:0] lane;
   logic [31:0] ld_data_d;

   always_comb begin
      illegal = 1'b0;
      if (is_store) illegal = funct3[2] | (funct3[1:0] == 2'b11);
      else          illegal = (funct3 == 3'b011) | (funct3[2:1] == 2'b11);
      if (funct3[1:0] == 2'b01 && addr[0])          illegal = 1'b1;
      if (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00) illegal = 1'b1;
   end

   // Lane placement only matters for legal accesses; illegal ones never reach the bus.
   always_comb begin
      be_d    = 4'b1111;
      wdata_d = wdata;
      case (funct3[1:0])
         2'b00: begin
            be_d    = 4'b0001 << addr[1:0];
            wdata_d = {4{wdata[7:0]}};
         end
         2'b01: begin
            be_d    = 4'b0011 << addr[1:0];
            wdata_d = {2{wdata[15:0]}};
         end
         default: begin
            be_d    = 4'b1111;
            wdata_d = wdata;
         end
      endcase
   end

   always_comb begin
      lane      = bus_rdata >> {off_q, 3'b000};
      ld_data_d = bus_rdata;
      case (f3_q)
         3'b000:  ld_data_d = {{24{lane[7]}}, lane[7:0]};
         3'b001:  ld_data_d = {{16{lane[15]}}, lane[15:0]};
         3'b100:  ld_data_d = {24'd0, lane[7:0]};
         3'b101:  ld_data_d = {16'd0, lane[15:0]};
         default: ld_data_d = bus_rdata;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         be_q    <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         f3_q    <= '0;
         off_q   <= '0;
`ifdef LSU_TIMEOUT_EN
         tmo_q   <= '0;
`endif
      end else begin
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
         case (state_q)
            IDLE: if (start) begin
               if (illegal) begin
                  state_q <= ERR;
                  err_q   <= 1'b1;
               end else begin
                  state_q <= REQ;
                  req_q   <= 1'b1;
                  we_q    <= is_store;
                  addr_q  <= {addr[31:2], 2'b00};
                  be_q    <= be_d;
                  wdata_q <= wdata_d;
                  f3_q    <= funct3;
                  off_q   <= addr[1:0];
`ifdef LSU_TIMEOUT_EN
                  tmo_q   <= '0;
`endif
               end
            end
            REQ: begin
               if (bus_ack) begin
                  state_q <= DONE;
                  req_q   <= 1'b0;
                  done_q  <= 1'b1;
                  rdata_q <= ld_data_d;
               end
`ifdef LSU_TIMEOUT_EN
               // 255th consecutive cycle without ack aborts; an ack on that cycle wins above.
               else if (tmo_q == 8'd254) begin
                  state_q <= ERR;
                  req_q   <= 1'b0;
                  err_q   <= 1'b1;
               end else begin
                  tmo_q   <= tmo_q + 8'd1;
               end
`endif
            end
            DONE:    state_q <= IDLE;
            ERR:     state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign stall     = rst_n & start & ((state_q == IDLE) | (state_q == REQ));
   assign done      = done_q;
   assign err       = err_q;
   assign rdata     = rdata_q;
   assign bus_req   = req_q;
   assign bus_we    = we_q;
   assign bus_addr  = addr_q;
   assign bus_be    = be_q;
   assign bus_wdata = wdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: vector table of single accesses plus reset, ack-ignore, start-drop and timeout sequences.
module tb_lsu_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, is_store, bus_ack;
   logic [2:0]  funct3;
   logic [31:0] addr, wdata, bus_rdata;
   logic        stall, done, err, bus_req, bus_we;
   logic [31:0] rdata, bus_addr, bus_wdata;
   logic [3:0]  bus_be;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   lsu_ctrl dut (
      .clk(clk), .rst_n(rst_n), .start(start), .is_store(is_store), .funct3(funct3),
      .addr(addr), .wdata(wdata), .stall(stall), .done(done), .err(err), .rdata(rdata),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
      .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
   );

   typedef struct {
      logic        st;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] wd;
      int          dly;
      logic [31:0] rd_in;
      logic        e_err;
      logic [3:0]  e_be;
      logic [31:0] e_addr;
      logic [31:0] e_wdata;
      logic [31:0] e_rdata;
   } vec_t;

   vec_t vecs[13];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int nstall = 0;
      @(negedge clk);
      start = 1'b1; is_store = v.st; funct3 = v.f3; addr = v.a; wdata = v.wd;
      #1;
      if (stall) nstall++;
      @(negedge clk);
      if (v.e_err) begin
         chk($sformatf("v%0d err", idx), {31'd0, err}, 32'd1);
         chk($sformatf("v%0d err_noreq", idx), {31'd0, bus_req}, 32'd0);
         chk($sformatf("v%0d err_stall", idx), {31'd0, stall}, 32'd0);
         chk($sformatf("v%0d stallcnt", idx), nstall, 32'd1);
         start = 1'b0;
         @(negedge clk);
         chk($sformatf("v%0d err_pulse", idx), {31'd0, err}, 32'd0);
         return;
      end
      chk($sformatf("v%0d req", idx), {31'd0, bus_req}, 32'd1);
      chk($sformatf("v%0d we", idx), {31'd0, bus_we}, {31'd0, v.st});
      chk($sformatf("v%0d addr", idx), bus_addr, v.e_addr);
      chk($sformatf("v%0d be", idx), {28'd0, bus_be}, {28'd0, v.e_be});
      chk($sformatf("v%0d wdata", idx), bus_wdata, v.e_wdata);
      for (int i = 0; i < v.dly; i++) begin
         if (stall) nstall++;
         @(negedge clk);
      end
      chk($sformatf("v%0d req_held", idx), {31'd0, bus_req}, 32'd1);
      chk($sformatf("v%0d be_held", idx), {28'd0, bus_be}, {28'd0, v.e_be});
      if (stall) nstall++;
      bus_ack = 1'b1; bus_rdata = v.rd_in;
      @(negedge clk);
      bus_ack = 1'b0; bus_rdata = 32'h5a5a_5a5a;
      chk($sformatf("v%0d done", idx), {31'd0, done}, 32'd1);
      chk($sformatf("v%0d rdata", idx), rdata, v.e_rdata);
      chk($sformatf("v%0d done_stall", idx), {31'd0, stall}, 32'd0);
      chk($sformatf("v%0d done_req", idx), {31'd0, bus_req}, 32'd0);
      chk($sformatf("v%0d stallcnt", idx), nstall, 2 + v.dly);
      start = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d done_pulse", idx), {31'd0, done}, 32'd0);
      chk($sformatf("v%0d rdata_clr", idx), rdata, 32'd0);
   endtask

   initial begin
      int n;
      int viol;
      //           st f3      addr          wdata         dly rd_in          err be       e_addr        e_wdata       e_rdata
      vecs[0]  = '{0, 3'b010, 32'h0000_0100, 32'h0,        0, 32'hDEAD_BEEF, 0, 4'b1111, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF};
      vecs[1]  = '{0, 3'b000, 32'h0000_0203, 32'h0,        2, 32'h80FF_FF7F, 0, 4'b1000, 32'h0000_0200, 32'h0,        32'hFFFF_FF80};
      vecs[2]  = '{0, 3'b100, 32'h0000_0203, 32'h0,        0, 32'h80FF_FF7F, 0, 4'b1000, 32'h0000_0200, 32'h0,        32'h0000_0080};
      vecs[3]  = '{1, 3'b001, 32'h0000_0012, 32'h0000_ABCD, 1, 32'h0,        0, 4'b1100, 32'h0000_0010, 32'hABCD_ABCD, 32'h0};
      vecs[4]  = '{0, 3'b010, 32'h0000_0101, 32'h0,        0, 32'h0,        1, 4'b0,    32'h0,        32'h0,        32'h0};
      vecs[5]  = '{0, 3'b001, 32'h0000_0102, 32'h0,        0, 32'h8001_1234, 0, 4'b1100, 32'h0000_0100, 32'h0,        32'hFFFF_8001};
      vecs[6]  = '{0, 3'b101, 32'h0000_0100, 32'h0,        3, 32'h8001_F234, 0, 4'b0011, 32'h0000_0100, 32'h0,        32'h0000_F234};
      vecs[7]  = '{1, 3'b000, 32'h0000_0001, 32'h1234_5678, 0, 32'h0,        0, 4'b0010, 32'h0000_0000, 32'h7878_7878, 32'h0};
      vecs[8]  = '{1, 3'b010, 32'h0000_0004, 32'hCAFE_F00D, 0, 32'h0,        0, 4'b1111, 32'h0000_0004, 32'hCAFE_F00D, 32'h0};
      vecs[9]  = '{0, 3'b001, 32'h0000_0003, 32'h0,        0, 32'h0,        1, 4'b0,    32'h0,        32'h0,        32'h0};
      vecs[10] = '{0, 3'b011, 32'h0000_0000, 32'h0,        0, 32'h0,        1, 4'b0,    32'h0,        32'h0,        32'h0};
      vecs[11] = '{1, 3'b100, 32'h0000_0000, 32'h0,        0, 32'h0,        1, 4'b0,    32'h0,        32'h0,        32'h0};
      vecs[12] = '{0, 3'b000, 32'h0000_0000, 32'h0,        1, 32'h0000_007F, 0, 4'b0001, 32'h0000_0000, 32'h0,        32'h0000_007F};

      rst_n = 1'b0; start = 1'b0; is_store = 1'b0; funct3 = 3'b0; addr = '0; wdata = '0;
      bus_ack = 1'b0; bus_rdata = '0;
      #12;
      chk("rst stall", {31'd0, stall}, 32'd0);
      chk("rst bus_req", {31'd0, bus_req}, 32'd0);
      chk("rst bus_addr", bus_addr, 32'd0);
      chk("rst rdata", rdata, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 13; i++) run_vec(i, vecs[i]);

      // ack outside REQ must not start or complete anything
      @(negedge clk);
      bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
      @(negedge clk);
      @(negedge clk);
      chk("ign done", {31'd0, done}, 32'd0);
      chk("ign req", {31'd0, bus_req}, 32'd0);
      bus_ack = 1'b0;

      // start drops mid-REQ: access still completes
      @(negedge clk);
      start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h40;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      chk("drop req", {31'd0, bus_req}, 32'd1);
      chk("drop stall", {31'd0, stall}, 32'd0);
      bus_ack = 1'b1; bus_rdata = 32'h1357_9BDF;
      @(negedge clk);
      bus_ack = 1'b0;
      chk("drop done", {31'd0, done}, 32'd1);
      chk("drop rdata", rdata, 32'h1357_9BDF);

      // reset in 3rd REQ cycle abandons the access
      @(negedge clk);
      start = 1'b1; funct3 = 3'b010; addr = 32'h100;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      chk("rstreq req", {31'd0, bus_req}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rstreq bus_req", {31'd0, bus_req}, 32'd0);
      chk("rstreq stall", {31'd0, stall}, 32'd0);
      chk("rstreq addr", bus_addr, 32'd0);
      chk("rstreq be", {28'd0, bus_be}, 32'd0);
      @(negedge clk);
      start = 1'b0; rst_n = 1'b1;
      viol = 0;
      for (int i = 0; i < 6; i++) begin
         bus_ack = (i == 1);
         @(negedge clk);
         if (done || err || bus_req) viol++;
      end
      bus_ack = 1'b0;
      chk("rstreq no_done", viol, 32'd0);

      // no ack at all
      @(negedge clk);
      start = 1'b1; funct3 = 3'b010; addr = 32'h200;
      @(negedge clk);
`ifdef LSU_TIMEOUT_EN
      n = 0;
      while (bus_req && n < 400) begin
         n++;
         @(negedge clk);
      end
      chk("tmo cycles", n, 32'd255);
      chk("tmo err", {31'd0, err}, 32'd1);
      start = 1'b0;
      @(negedge clk);
`else
      viol = 0;
      for (int i = 0; i < 300; i++) begin
         if (!stall || !bus_req || err) viol++;
         @(negedge clk);
      end
      chk("hang stall", viol, 32'd0);
      bus_ack = 1'b1;
      @(negedge clk);
      bus_ack = 1'b0; start = 1'b0;
      chk("hang done", {31'd0, done}, 32'd1);
      @(negedge clk);
      n = 0;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 clk  in  1  single clock, all state on rising edge.
REQ-002 rst_n  in  1  asynchronous, active-low reset.
REQ-003 start  in  1  decoded load/store present in current instruction; held high by core until done or err.
REQ-004 is_store  in  1  1=store (SB/SH/SW), 0=load (LB/LH/LW/LBU/LHU).
REQ-005 funct3  in  3  inst[14:12] width/sign code.
REQ-006 addr  in  32  effective byte address from ALU.
REQ-007 wdata  in  32  rs2 store data, right-aligned.
REQ-008 stall  out  1  freeze PC/regfile write while access in progress.
REQ-009 done  out  1  one-cycle pulse, access complete.
REQ-010 err  out  1  one-cycle pulse, access aborted.
REQ-011 rdata  out  32  extended load result, valid while done=1.
REQ-012 bus_req  out  1  memory request.
REQ-013 bus_we  out  1  1=write.
REQ-014 bus_addr  out  32  word address, addr with [1:0]=00.
REQ-015 bus_be  out  4  byte enables.
REQ-016 bus_wdata  out  32  store data replicated into addressed lane(s).
REQ-017 bus_ack  in  1  memory completion, may arrive any cycle >=1 after bus_req.
REQ-018 bus_rdata  in  32  read word, valid with bus_ack.

Function
REQ-019 FSM states IDLE, REQ, DONE, ERR; encoding free.
REQ-020 IDLE: start=0 -> stay; start=1 and legal -> REQ; start=1 and illegal -> ERR.
REQ-021 Illegal: load funct3 in {011,110,111}; store funct3 >= 011; halfword with addr[0]=1; word with addr[1:0]!=00.
REQ-022 REQ: bus_req=1, bus_we/addr/be/wdata registered on IDLE->REQ exit and held stable until bus_ack.
REQ-023 REQ + bus_ack=1 -> DONE, bus_rdata captured same edge; bus_ack=0 -> stay.
REQ-024 DONE: done=1, stall=0, rdata from captured word; next state IDLE unconditionally.
REQ-025 ERR: err=1, stall=0, bus_req=0; next state IDLE unconditionally.
REQ-026 stall = start AND state in {IDLE, REQ}; combinational.
REQ-027 Minimum latency start->done: 2 cycles after start (IDLE, REQ with ack, DONE on third cycle).
REQ-028 bus_be: byte 0001<<addr[1:0]; half 0011<<addr[1:0] (addr[1] in {0,1}); word 1111.
REQ-029 bus_wdata: byte = {4{wdata[7:0]}}; half = {2{wdata[15:0]}}; word = wdata.
REQ-030 rdata: LB/LH sign-extend selected lane; LBU/LHU zero-extend; LW full word; rdata=0 outside DONE.
REQ-031 bus_ack while not in REQ ignored.
REQ-032 start dropping mid-REQ does not abort: transaction completes, done still pulses.

Reset
REQ-033 rst_n=0 -> state IDLE immediately; stall, done, err, bus_req, bus_we = 0; bus_addr, bus_be, bus_wdata, rdata, captured word = 0.
REQ-034 Reset during REQ abandons transaction; no done/err pulse after deassertion.

Configuration
REQ-035 Macro LSU_TIMEOUT_EN defined: 8-bit counter cleared on REQ entry, increments each REQ cycle without bus_ack; reaching 255 -> ERR with bus_req dropped; ack on the 255th cycle takes priority (-> DONE).
REQ-036 LSU_TIMEOUT_EN undefined: no counter; REQ waits indefinitely.

Verification
REQ-037 LW addr=0x100, bus_ack 1 cycle after req, bus_rdata=0xDEADBEEF -> bus_be=1111, bus_addr=0x100, done with rdata=0xDEADBEEF, stall high exactly 2 cycles.
REQ-038 LB addr=0x203, bus_rdata=0x80FF_FF7F -> bus_be=1000, rdata=0xFFFFFF80; LBU same -> rdata=0x00000080.
REQ-039 SH addr=0x12, wdata=0x0000ABCD -> bus_we=1, bus_addr=0x10, bus_be=1100, bus_wdata=0xABCDABCD, done pulse.
REQ-040 LW addr=0x101 -> err pulse second cycle, bus_req never asserted, stall 1 cycle.
REQ-041 LW with bus_ack delayed 5 cycles, rst_n pulsed low in 3rd REQ cycle -> all outputs 0, IDLE, no done.
REQ-042 LSU_TIMEOUT_EN defined, bus_ack never -> err after 255 REQ cycles; undefined -> stall held indefinitely.
